// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin sharing of one external PISO among NREQ word producers.
module piso_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   grant,
  output logic              piso_ctrl,
  output logic [W-1:0]      piso_d,
  output logic              bit_valid,
  output logic              bit_first,
  output logic              bit_last,
  output logic [IDW-1:0]    owner,
  output logic              busy
);
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IDW-1:0] ptr, ptr_nx, owner_nx, win, k;
  logic found, last, arb;
  always_comb begin
    found = 1'b0;
    win = '0;
    k = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[k]) begin
        found = 1'b1;
        win = k;
      end
    end
  end
  // A new word is loaded from IDLE or on the final shift cycle, so frames can run back-to-back.
  always_comb begin
    last = cnt == CW'(W - 1);
    arb = rst_n && found && (state == IDLE || last);
    grant = arb ? (NREQ'(1) << win) : '0;
    piso_d = arb ? data[int'(win)*W +: W] : '0;
    busy = rst_n && state == SHIFT;
    piso_ctrl = busy && !last;
    bit_valid = busy;
    bit_first = busy && cnt == '0;
    bit_last = busy && last;
    state_nx = state;
    cnt_nx = cnt;
    ptr_nx = ptr;
    owner_nx = owner;
    if (arb) begin
      state_nx = SHIFT;
      cnt_nx = '0;
      ptr_nx = win;
      owner_nx = win;
    end else if (busy && !last) begin
      cnt_nx = cnt + 1'b1;
    end else if (busy) begin
      state_nx = IDLE;
      cnt_nx = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= IDW'(NREQ - 1);
      owner <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
      owner <= owner_nx;
    end
  end
endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Round-robin controller that shares one external parallel-in/serial-out shift register among `NREQ` requesters. It grants one requester at a time, drives the PISO's load/shift control and parallel data, and counts the `W` shift cycles. It also publishes framing flags aligned with the PISO's serial output `Q0`. It sits between the word producers and the PISO in the serial transmit path.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `W`, 4: word width, which is also the PISO width; ≥2.
- `IDW`, `$clog2(NREQ)`: requester index width (derived, not overridden).

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  NREQ  per-requester request level; the word must stay stable while high.
- `data`  in  NREQ*W  packed words; requester i is `data[i*W +: W]`.
- `grant`  out  NREQ  one-hot, one-cycle pulse; the word is accepted on this edge.
- `piso_ctrl`  out  1  PISO control: 0 = load `piso_d`, 1 = shift.
- `piso_d`  out  W  parallel word to the PISO.
- `bit_valid`  out  1  PISO `Q0` carries a payload bit this cycle.
- `bit_first`  out  1  `Q0` is the word MSB.
- `bit_last`  out  1  `Q0` is the word LSB.
- `owner`  out  IDW  index of the requester whose word is in the PISO.
- `busy`  out  1  a word is being shifted.

## Operation
- **PISO contract** (fixed for this block):
  - On a `clk` edge with `piso_ctrl=0`, the PISO loads `piso_d` and `Q0` then shows `piso_d[W-1]`.
  - On a `clk` edge with `piso_ctrl=1`, the PISO shifts and `Q0` shows the next lower bit. Words go out MSB first.
- **States:** IDLE and SHIFT. The shift counter `cnt` runs 0..W-1. The pointer `ptr` holds the last granted index.
- **Arbitration:** search starts at `(ptr+1) mod NREQ` and wraps. The first asserted `req` wins.
  - `grant[k]=1` in the same cycle (Mealy, from registered state plus `req`).
  - `piso_ctrl=0`, `piso_d=data[k]`.
  - At the edge: `ptr<=k`, `owner<=k`, `cnt<=0`, state becomes SHIFT.
- **IDLE:**
  - `piso_ctrl=0`, `busy=0`, `bit_*=0`.
  - `piso_d` = the winner's word, or 0 when there is no request.
  - Arbitration runs every cycle.
- **SHIFT:**
  - `busy=1`, `bit_valid=1`, `bit_first=(cnt==0)`, `bit_last=(cnt==W-1)`.
  - While `cnt<W-1`: `piso_ctrl=1`, `piso_d=0`, `cnt` increments.
  - At `cnt==W-1` with any `req`: arbitrate and load, giving a back-to-back word with no bubble. State stays SHIFT and `cnt<=0`.
  - At `cnt==W-1` with no `req`: `piso_ctrl=0`, `piso_d=0`, next state IDLE.
- **Requests:**
  - Dropping `req` during another requester's frame has no effect.
  - A granted requester re-requesting competes normally and gets lowest priority next round.
- **Reset:** `rst_n` is sampled on `clk`.
  - While low, `grant=0`, `piso_ctrl=0`, `piso_d=0`, `bit_*=0`, `busy=0`.
  - At the edge: state IDLE, `cnt=0`, `ptr=NREQ-1` (so req0 has first priority), `owner=0`.
  - Reset mid-frame aborts the word. The PISO contents are don't-care and no `bit_valid` is issued for it.

## Timing
- From IDLE: `grant` in cycle t; `Q0`/`bit_valid` in cycles t+1..t+W; `bit_first` at t+1, `bit_last` at t+W.
- Back-to-back: next grant coincides with the `bit_last` cycle; the next word's MSB comes at the following cycle. Sustained throughput is one word per W cycles.
- Idle gap after an unfollowed frame: at least 1 cycle (IDLE) before the next `bit_valid`.
- `owner` changes only on the grant edge and is constant for the whole W-cycle frame.
- All registers update only on the rising edge of `clk`. Outputs settle combinationally from registers plus `req`/`data`.

## Test plan
- **Single word:** reset, then req0 with `data0=4'b1001` at cycle t.
  - `grant=0001` at t.
  - `Q0=1,0,0,1` at t+1..t+4.
  - `bit_first` at t+1, `bit_last` at t+4, `owner=0`, IDLE at t+5.
- **Full round-robin:** all four `req` held with words 1001, 0110, 1111, 0001.
  - Grants are 0,1,2,3,0, spaced exactly 4 cycles apart.
  - `bit_valid` is continuous with no gap.
  - Serial stream is 1001 0110 1111 0001 1001.
- **Pointer fairness:** after a grant to 2, `req=1010`; the next grant goes to 3, then to 1.
- **Drop mid-frame:** req1 is granted, then req0 rises and req1 falls at `cnt=1`.
  - req1's frame completes unchanged.
  - req0 is granted at the `bit_last` cycle.
- **Reset mid-frame:** `rst_n=0` for 1 cycle at `cnt=2`.
  - `bit_valid=0` and `piso_ctrl=0` in that cycle; IDLE after.
  - With all `req` then asserted, the first grant is `0001`.
- **Idle hold:** `req=0` for 10 cycles after reset: `piso_ctrl=0`, `piso_d=0`, `grant=0`, `busy=0` throughout.
